// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair
// Optional build macro: MULDIV_FAST_MULT_EN (single-cycle registered multiply in CALC).
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   m_q, m_d;          // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;      // product accumulator or {remainder, quotient}
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand magnitudes; unsigned ops (op[0]=1) never record a sign.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    assign a_neg = ~op[0] & opa[WIDTH-1];
    assign b_neg = ~op[0] & opb[WIDTH-1];
    assign a_abs = a_neg ? -opa : opa;
    assign b_abs = b_neg ? -opb : opb;

    // Restoring divide step: shift {rem,quot} left, trial-subtract the divisor.
    // The shifted remainder is WIDTH+1 bits; its top bit forces a subtract.
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= m_q);
    assign rem_new  = div_ge ? (rem_sh[WIDTH-1:0] - m_q) : rem_sh[WIDTH-1:0];
    assign div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] mul_next;
    assign mul_next = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
    // LSB-first shift-add step: conditionally add multiplicand to upper half, shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`endif

    logic [2*WIDTH-1:0] acc_neg;
    logic [WIDTH-1:0]   quot_neg, rem_neg;
    assign acc_neg  = -acc_q;
    assign quot_neg = -acc_q[WIDTH-1:0];
    assign rem_neg  = -acc_q[2*WIDTH-1:WIDTH];

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            m_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Next-state, datapath step and HI/LO write-back selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        m_d      = m_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    is_div_d = op[1];
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    cnt_d    = CW'(WIDTH - 1);
                    if (op[1] && (opb == '0)) begin
                        // Divide by zero: quotient all ones, remainder is the raw dividend.
                        state_d  = S_FIX;
                        acc_d    = {opa, {WIDTH{1'b1}}};
                        sign_a_d = 1'b0;
                        sign_b_d = 1'b0;
                    end else if (op[1]) begin
                        state_d = S_CALC;
                        m_d     = b_abs;
                        acc_d   = {{WIDTH{1'b0}}, a_abs};
                    end else begin
                        state_d = S_CALC;
                        m_d     = a_abs;
                        acc_d   = {{WIDTH{1'b0}}, b_abs};
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (is_div_q) begin
                    acc_d = div_next;
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - CW'(1);
                end else begin
                    acc_d = mul_next;
`ifdef MULDIV_FAST_MULT_EN
                    cnt_d   = '0;
                    state_d = S_FIX;
`else
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - CW'(1);
`endif
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = sign_a_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
                        lo_d = (sign_a_q ^ sign_b_q) ? quot_neg : acc_q[WIDTH-1:0];
                    end else begin
                        {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? acc_neg : acc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized self-checking bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic        flush;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_hi, m_lo;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] ua, ub;
        ua = {32'b0, a};
        ub = {32'b0, b};
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (o)
            2'd0: return x * y;
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = x / y;
                r = x % y;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] b);
        if (o[1] && b == 0) return 1;
`ifdef MULDIV_FAST_MULT_EN
        if (!o[1]) return 2;
`endif
        return 33;
    endfunction

    // Issue one operation, optionally poke start/MTHI/MTLO while busy, and check the result.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [63:0] r;
        int lat, got_lat, bcnt;
        r   = model(o, a, b);
        lat = exp_latency(o, b);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0;
        got_lat = 0;
        bcnt    = 0;
        for (int k = 1; k <= 60; k++) begin
            if (busy) bcnt++;
            if (poke && k == 2 && lat > 2) begin
                start = 1'b1; op = ~o; opa = ~a; opb = b + 32'd1;
                hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (done) begin
                got_lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 64'(got_lat), 64'(lat));
        check({tag, "_bcnt"}, 64'(bcnt), 64'(lat));
        check({tag, "_hi"}, {32'b0, hi}, {32'b0, r[63:32]});
        check({tag, "_lo"}, {32'b0, lo}, {32'b0, r[31:0]});
        check({tag, "_busy0"}, {63'b0, busy}, 64'd0);
        m_hi = r[63:32];
        m_lo = r[31:0];
        @(posedge clk); #1;
        check({tag, "_pulse"}, {63'b0, done}, 64'd0);
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
        @(negedge clk);
        hi_we = wh; lo_we = wl; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          seen_done;

        rst_n = 1'b0; start = 1'b0; op = 2'd0; opa = '0; opb = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi_const", {32'b0, m_hi}, 64'hFFFF_FFFE);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_zero", 2'd3, 32'd100, 32'd0, 1'b0);
        run_op("div_zero_s", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);

        // MTHI then a flushed MULT: no done, HI kept; then MTLO.
        mt_write(1'b1, 1'b0, 32'h1234);
        check("mthi", {32'b0, hi}, 64'h1234);
        @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 32'd2; opb = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        seen_done = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", {63'b0, busy}, 64'd0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("flush_nodone", {63'b0, seen_done}, 64'd0);
        check("flush_hi", {32'b0, hi}, {32'b0, m_hi});
        check("flush_lo", {32'b0, lo}, {32'b0, m_lo});
        mt_write(1'b0, 1'b1, 32'h55);
        check("mtlo", {32'b0, lo}, 64'h55);
        check("mtlo_hi", {32'b0, hi}, 64'h1234);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
        check("mt_both_hi", {32'b0, hi}, 64'hCAFE_F00D);
        check("mt_both_lo", {32'b0, lo}, 64'hCAFE_F00D);

        // Start together with flush in IDLE: nothing begins.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'd3; opa = 32'd9; opb = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #1;
        check("flush_start_done", {63'b0, done}, 64'd0);

        // Start together with MTHI/MTLO in IDLE: start wins, writes dropped.
        @(negedge clk);
        start = 1'b1; op = 2'd1; opa = 32'd5; opb = 32'd6;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("start_wins_busy", {63'b0, busy}, 64'd1);
        check("start_wins_hi", {32'b0, hi}, {32'b0, m_hi});
        check("start_wins_lo", {32'b0, lo}, {32'b0, m_lo});
        for (int k = 0; k < 40 && busy; k++) begin
            @(posedge clk); #1;
        end
        check("start_wins_res_lo", {32'b0, lo}, 64'd30);
        check("start_wins_res_hi", {32'b0, hi}, 64'd0);
        m_hi = '0; m_lo = 32'd30;

        // Randomized operations against the model.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                3: begin ra = -32'($urandom_range(0, 50)); rb = -32'($urandom_range(1, 9)); end
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        // Reset mid-DIVU with start/MTLO pulsed while busy.
        mt_write(1'b1, 1'b1, 32'h7777_7777);
        @(negedge clk);
        start = 1'b1; op = 2'd3; opa = 32'd1000; opb = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 3) begin
                start = 1'b1; lo_we = 1'b1; wdata = 32'h1111_2222; opb = 32'd0;
            end
            @(posedge clk); #1;
            start = 1'b0; lo_we = 1'b0;
            if (k == 5) begin
                check("busy_poke_busy", {63'b0, busy}, 64'd1);
                check("busy_poke_lo", {32'b0, lo}, 64'h7777_7777);
                check("busy_poke_hi", {32'b0, hi}, 64'h7777_7777);
            end
        end
        rst_n = 1'b0;
        #1;
        check("amid_rst_hi", {32'b0, hi}, 64'd0);
        check("amid_rst_lo", {32'b0, lo}, 64'd0);
        check("amid_rst_busy", {63'b0, busy}, 64'd0);
        check("amid_rst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", {63'b0, busy}, 64'd0);
        run_op("post_rst_divu", 2'd3, 32'd1000, 32'd7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
